// File: rtl/ord_dispatcher.sv
// Request fork for the reorder buffer: one holding entry feeds the slave request
// channel and the order channel, gated by per-ID beat credits.
module ord_dispatcher #(
   parameter int ORD_DEPTH = 4,
   parameter int ID_W      = $clog2(ORD_DEPTH),
   parameter int LEN_W     = 16,
   parameter int BUF_DEPTH = 16,
   parameter int CRD_W     = $clog2(BUF_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ID_W-1:0]            req_id,
   input  logic [LEN_W-1:0]           req_len,
   input  logic                       req_vld,
   output logic                       req_rdy,
   output logic [ID_W-1:0]            m_id,
   output logic [LEN_W-1:0]           m_len,
   output logic                       m_vld,
   input  logic                       m_rdy,
   output logic [ID_W-1:0]            ord_id,
   output logic [LEN_W-1:0]           ord_len,
   output logic                       ord_vld,
   input  logic                       ord_rdy,
   input  logic [ID_W-1:0]            ret_id,
   input  logic                       ret_vld,
   output logic                       err_len,
   output logic [ORD_DEPTH*CRD_W-1:0] crd_o
);

   localparam logic [LEN_W:0]   BUF_LIM  = (LEN_W + 1)'(BUF_DEPTH);
   localparam logic [CRD_W-1:0] CRD_INIT = CRD_W'(BUF_DEPTH);

   logic [ID_W-1:0]  hold_id_reg;
   logic [LEN_W-1:0] hold_len_reg;
   logic             hold_vld_reg;
   logic             m_done_reg;
   logic             o_done_reg;
   logic             err_len_reg;
   logic [CRD_W-1:0] crd_reg  [ORD_DEPTH];
   logic [CRD_W-1:0] crd_next [ORD_DEPTH];

   logic             m_hsk;
   logic             o_hsk;
   logic             fire;
   logic [LEN_W:0]   need;
   logic [CRD_W-1:0] crd_sel;
   logic             ok;
   logic             oversize;
   logic             accept;
   logic             accept_norm;

   assign m_vld   = hold_vld_reg & ~m_done_reg;
   assign ord_vld = hold_vld_reg & ~o_done_reg;
   assign m_id    = hold_id_reg;
   assign m_len   = hold_len_reg;
   assign ord_id  = hold_id_reg;
   assign ord_len = hold_len_reg;
   assign err_len = err_len_reg;

   assign m_hsk = m_vld & m_rdy;
   assign o_hsk = ord_vld & ord_rdy;
   assign fire  = hold_vld_reg & (m_done_reg | m_hsk) & (o_done_reg | o_hsk);

   // need is one bit wider than len so that len = all-ones cannot wrap to zero
   assign need     = {1'b0, req_len} + (LEN_W + 1)'(1);
   assign crd_sel  = crd_reg[req_id];
   assign ok       = (LEN_W + 1)'(crd_sel) >= need;
   assign oversize = need > BUF_LIM;

   assign req_rdy     = (~hold_vld_reg | fire) & (ok | oversize);
   assign accept      = req_vld & req_rdy;
   assign accept_norm = accept & ~oversize;

   generate
      for (genvar gi = 0; gi < ORD_DEPTH; gi++) begin : g_crd
         logic           ret_hit;
         logic [LEN_W:0] ded;
         logic [LEN_W:0] sum;

         assign ret_hit = ret_vld && (ret_id == ID_W'(gi));
         assign ded     = (accept_norm && (req_id == ID_W'(gi))) ? need : '0;
         // ded never exceeds the registered credit, so sum cannot underflow
         assign sum     = (LEN_W + 1)'(crd_reg[gi]) + (LEN_W + 1)'(ret_hit) - ded;
         assign crd_next[gi] = (sum > BUF_LIM) ? CRD_INIT : sum[CRD_W-1:0];
         assign crd_o[(gi+1)*CRD_W-1 -: CRD_W] = crd_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ORD_DEPTH; i++) begin
            crd_reg[i] <= CRD_INIT;
         end
      end else begin
         for (int i = 0; i < ORD_DEPTH; i++) begin
            crd_reg[i] <= crd_next[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_id_reg  <= '0;
         hold_len_reg <= '0;
         hold_vld_reg <= 1'b0;
         m_done_reg   <= 1'b0;
         o_done_reg   <= 1'b0;
         err_len_reg  <= 1'b0;
      end else begin
         err_len_reg <= accept & oversize;
         // a new load may coincide with the fire of the previous entry
         if (accept_norm) begin
            hold_id_reg  <= req_id;
            hold_len_reg <= req_len;
            hold_vld_reg <= 1'b1;
            m_done_reg   <= 1'b0;
            o_done_reg   <= 1'b0;
         end else if (fire) begin
            hold_vld_reg <= 1'b0;
            m_done_reg   <= 1'b0;
            o_done_reg   <= 1'b0;
         end else begin
            if (m_hsk) m_done_reg <= 1'b1;
            if (o_hsk) o_done_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ord_dispatcher.sv
// Directed bench for ord_dispatcher: fork handshakes, credit accounting,
// oversized drops and asynchronous reset, against hand-computed values.
module tb_ord_dispatcher;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_id;
   logic [15:0] req_len;
   logic        req_vld;
   logic        req_rdy;
   logic [1:0]  m_id;
   logic [15:0] m_len;
   logic        m_vld;
   logic        m_rdy;
   logic [1:0]  ord_id;
   logic [15:0] ord_len;
   logic        ord_vld;
   logic        ord_rdy;
   logic [1:0]  ret_id;
   logic        ret_vld;
   logic        err_len;
   logic [19:0] crd_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ord_dispatcher dut (
      .clk     (clk),
      .rst     (rst),
      .req_id  (req_id),
      .req_len (req_len),
      .req_vld (req_vld),
      .req_rdy (req_rdy),
      .m_id    (m_id),
      .m_len   (m_len),
      .m_vld   (m_vld),
      .m_rdy   (m_rdy),
      .ord_id  (ord_id),
      .ord_len (ord_len),
      .ord_vld (ord_vld),
      .ord_rdy (ord_rdy),
      .ret_id  (ret_id),
      .ret_vld (ret_vld),
      .err_len (err_len),
      .crd_o   (crd_o)
   );

   function automatic logic [31:0] crd(input int i);
      return 32'(crd_o[i*5 +: 5]);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s = %0d", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_req(input logic v, input logic [1:0] id, input logic [15:0] len);
      req_vld = v;
      req_id  = id;
      req_len = len;
   endtask

   initial begin
      rst = 1'b1;
      drive_req(1'b0, 2'd0, 16'd0);
      m_rdy = 1'b1; ord_rdy = 1'b1; ret_id = 2'd0; ret_vld = 1'b0;
      #2;
      // reset state
      check("rst_m_vld", 32'(m_vld), 0);
      check("rst_ord_vld", 32'(ord_vld), 0);
      check("rst_err_len", 32'(err_len), 0);
      check("rst_m_id", 32'(m_id), 0);
      check("rst_ord_len", 32'(ord_len), 0);
      for (int i = 0; i < 4; i++) check($sformatf("rst_crd%0d", i), crd(i), 16);
      tick();
      rst = 1'b0;
      tick();

      // return to a full ID saturates
      ret_vld = 1'b1; ret_id = 2'd3;
      tick();
      ret_vld = 1'b0;
      check("sat_crd3", crd(3), 16);

      // basic request, latency 1
      drive_req(1'b1, 2'd1, 16'd3);
      settle();
      check("t1_req_rdy", 32'(req_rdy), 1);
      tick();
      drive_req(1'b0, 2'd0, 16'd0);
      check("t1_m_vld", 32'(m_vld), 1);
      check("t1_ord_vld", 32'(ord_vld), 1);
      check("t1_m_id", 32'(m_id), 1);
      check("t1_m_len", 32'(m_len), 3);
      check("t1_ord_id", 32'(ord_id), 1);
      check("t1_ord_len", 32'(ord_len), 3);
      check("t1_crd1", crd(1), 12);
      check("t1_crd0", crd(0), 16);
      check("t1_crd2", crd(2), 16);
      tick();
      check("t1_m_vld_after", 32'(m_vld), 0);

      // fork skew: slave side stalls, order side completes first
      m_rdy = 1'b0;
      drive_req(1'b1, 2'd0, 16'd0);
      tick();
      drive_req(1'b1, 2'd0, 16'd0);
      check("t2_m_vld0", 32'(m_vld), 1);
      check("t2_ord_vld0", 32'(ord_vld), 1);
      check("t2_req_rdy0", 32'(req_rdy), 0);
      tick();
      check("t2_ord_vld1", 32'(ord_vld), 0);
      check("t2_m_vld1", 32'(m_vld), 1);
      check("t2_req_rdy1", 32'(req_rdy), 0);
      tick();
      check("t2_m_vld2", 32'(m_vld), 1);
      check("t2_req_rdy2", 32'(req_rdy), 0);
      m_rdy = 1'b1;
      settle();
      check("t2_req_rdy_fire", 32'(req_rdy), 1);
      tick();
      drive_req(1'b0, 2'd0, 16'd0);
      check("t2_reload_m_vld", 32'(m_vld), 1);
      check("t2_reload_ord_vld", 32'(ord_vld), 1);
      check("t2_crd0", crd(0), 14);
      tick();
      check("t2_idle_m_vld", 32'(m_vld), 0);

      // credit exhaustion on ID 2, back-to-back accepts
      drive_req(1'b1, 2'd2, 16'd3);
      for (int k = 0; k < 4; k++) begin
         settle();
         check($sformatf("t3_acc%0d_rdy", k), 32'(req_rdy), 1);
         tick();
      end
      check("t3_crd2_empty", crd(2), 0);
      check("t3_blocked0", 32'(req_rdy), 0);
      tick();
      check("t3_blocked1", 32'(req_rdy), 0);
      ret_vld = 1'b1; ret_id = 2'd2;
      tick();
      ret_vld = 1'b0;
      settle();
      check("t3_crd2_one", crd(2), 1);
      check("t3_blocked2", 32'(req_rdy), 0);
      ret_vld = 1'b1;
      tick(); tick(); tick();
      ret_vld = 1'b0;
      settle();
      check("t3_crd2_four", crd(2), 4);
      check("t3_unblocked", 32'(req_rdy), 1);
      tick();
      drive_req(1'b0, 2'd0, 16'd0);
      check("t3_crd2_after", crd(2), 0);
      check("t3_m_id", 32'(m_id), 2);
      tick();

      // simultaneous deduct and return on ID 3
      drive_req(1'b1, 2'd3, 16'd10);
      tick();
      drive_req(1'b0, 2'd0, 16'd0);
      check("t4_crd3_five", crd(3), 5);
      tick();
      drive_req(1'b1, 2'd3, 16'd1);
      ret_vld = 1'b1; ret_id = 2'd3;
      settle();
      check("t4_req_rdy", 32'(req_rdy), 1);
      tick();
      drive_req(1'b0, 2'd0, 16'd0);
      ret_vld = 1'b0;
      check("t4_crd3", crd(3), 4);
      tick();

      // oversized and boundary lengths
      drive_req(1'b1, 2'd1, 16'd15);
      settle();
      check("t5_need16_blocked", 32'(req_rdy), 0);
      drive_req(1'b1, 2'd1, 16'hFFFF);
      settle();
      check("t5_maxlen_rdy", 32'(req_rdy), 1);
      drive_req(1'b1, 2'd0, 16'd16);
      settle();
      check("t5_over_rdy", 32'(req_rdy), 1);
      tick();
      drive_req(1'b0, 2'd0, 16'd0);
      check("t5_err_len", 32'(err_len), 1);
      check("t5_m_vld", 32'(m_vld), 0);
      check("t5_ord_vld", 32'(ord_vld), 0);
      check("t5_crd0", crd(0), 14);
      tick();
      check("t5_err_len_clear", 32'(err_len), 0);

      // reset while a request is held
      m_rdy = 1'b0; ord_rdy = 1'b0;
      drive_req(1'b1, 2'd0, 16'd5);
      tick();
      drive_req(1'b0, 2'd0, 16'd0);
      check("t6_crd0", crd(0), 8);
      check("t6_m_vld", 32'(m_vld), 1);
      rst = 1'b1;
      settle();
      check("t6_rst_m_vld", 32'(m_vld), 0);
      check("t6_rst_ord_vld", 32'(ord_vld), 0);
      for (int i = 0; i < 4; i++) check($sformatf("t6_rst_crd%0d", i), crd(i), 16);
      tick();
      rst = 1'b0;
      m_rdy = 1'b1; ord_rdy = 1'b1;
      drive_req(1'b1, 2'd2, 16'd15);
      settle();
      check("t6_post_rdy", 32'(req_rdy), 1);
      tick();
      drive_req(1'b0, 2'd0, 16'd0);
      check("t6_post_crd2", crd(2), 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
